// File: rtl/motor_fault_supervisor_if.sv
// Signal bundle between the motor controller and motor_fault_supervisor.
// The controller side uses the master modport; the supervisor uses the slave modport.
interface motor_fault_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             fault_in;
    logic [15:0]      speed_in;
    logic             clear_req;
    logic             motor_en;
    logic             trip;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] trip_count;
    logic [15:0]      trip_speed;

    modport master (
        output enable,
        output fault_in,
        output speed_in,
        output clear_req,
        input  motor_en,
        input  trip,
        input  state_o,
        input  trip_count,
        input  trip_speed
    );

    modport slave (
        input  enable,
        input  fault_in,
        input  speed_in,
        input  clear_req,
        output motor_en,
        output trip,
        output state_o,
        output trip_count,
        output trip_speed
    );
endinterface

// File: rtl/motor_fault_supervisor.sv
// Motor protection FSM: debounces the over-current flag, latches trips, enforces a cooldown before clear.
// Optional trip-speed logging is built when MOTOR_FAULT_SUPERVISOR_SPEED_LOG_EN is defined.
module motor_fault_supervisor #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int COOLDOWN_CYCLES = 1000,
    parameter int CNT_W           = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    motor_fault_supervisor_if.slave   bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RUN  = 3'd1;
    localparam logic [2:0] PEND = 3'd2;
    localparam logic [2:0] TRIP = 3'd3;
    localparam logic [2:0] COOL = 3'd4;

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COOL_MAX = CW'(COOLDOWN_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [DW-1:0]    deb_q, deb_d;
    logic [CW-1:0]    cool_q, cool_d;
    logic [CNT_W-1:0] trip_count_q;
    logic             trip_entry;

    always_comb begin
        state_d    = state_q;
        deb_d      = deb_q;
        cool_d     = cool_q;
        trip_entry = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = RUN;
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (bus.fault_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = TRIP;
                        trip_entry = 1'b1;
                    end else begin
                        state_d = PEND;
                        deb_d   = DW'(1);
                    end
                end
            end
            PEND: begin
                if (!bus.enable || !bus.fault_in) begin
                    state_d = bus.enable ? RUN : IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    // This edge samples the final consecutive fault, so motor_en drops now.
                    state_d    = TRIP;
                    deb_d      = '0;
                    trip_entry = 1'b1;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            TRIP: begin
                if (!bus.fault_in) begin
                    state_d = COOL;
                    cool_d  = '0;
                end
            end
            COOL: begin
                if (bus.fault_in) begin
                    state_d = TRIP;
                    cool_d  = '0;
                end else if (cool_q == COOL_MAX && bus.clear_req) begin
                    state_d = bus.enable ? RUN : IDLE;
                    cool_d  = '0;
                end else if (cool_q != COOL_MAX) begin
                    cool_d = cool_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                deb_d   = '0;
                cool_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            deb_q        <= '0;
            cool_q       <= '0;
            trip_count_q <= '0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            cool_q  <= cool_d;
            if (trip_entry && trip_count_q != '1) begin
                trip_count_q <= trip_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.motor_en   = (state_q == RUN) || (state_q == PEND);
    assign bus.trip       = (state_q == TRIP) || (state_q == COOL);
    assign bus.state_o    = state_q;
    assign bus.trip_count = trip_count_q;

`ifdef MOTOR_FAULT_SUPERVISOR_SPEED_LOG_EN
    logic [15:0] trip_speed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trip_speed_q <= '0;
        end else if (trip_entry) begin
            trip_speed_q <= bus.speed_in;
        end
    end

    assign bus.trip_speed = trip_speed_q;
`else
    logic speed_unused;

    assign speed_unused   = ^bus.speed_in;
    assign bus.trip_speed = 16'd0;
`endif
endmodule

// File: tb/tb_motor_fault_supervisor.sv
// Directed, table-driven bench for motor_fault_supervisor (DEBOUNCE_CYCLES=8, COOLDOWN_CYCLES=16).
// Expected trip_speed follows MOTOR_FAULT_SUPERVISOR_SPEED_LOG_EN.
module tb_motor_fault_supervisor;
    localparam int DEB   = 8;
    localparam int COOL  = 16;
    localparam int CNT_W = 8;

`ifdef MOTOR_FAULT_SUPERVISOR_SPEED_LOG_EN
    localparam logic [15:0] SPD_A = 16'd1200;
    localparam logic [15:0] SPD_B = 16'd777;
    localparam logic [15:0] SPD_C = 16'd4321;
`else
    localparam logic [15:0] SPD_A = 16'd0;
    localparam logic [15:0] SPD_B = 16'd0;
    localparam logic [15:0] SPD_C = 16'd0;
`endif

    typedef struct {
        logic        en;
        logic        flt;
        logic        clr;
        logic [15:0] spd;
        int          cycles;
        logic [2:0]  st;
        logic        men;
        logic        trp;
        logic [7:0]  cnt;
        logic [15:0] tspd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    vec_t vecs[$];

    motor_fault_supervisor_if #(.CNT_W(CNT_W)) bus ();

    motor_fault_supervisor #(
        .DEBOUNCE_CYCLES(DEB),
        .COOLDOWN_CYCLES(COOL),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(logic en, logic flt, logic clr, logic [15:0] spd, int cycles,
                                    logic [2:0] st, logic men, logic trp, logic [7:0] cnt,
                                    logic [15:0] tspd);
        vec_t v;
        v.en = en; v.flt = flt; v.clr = clr; v.spd = spd; v.cycles = cycles;
        v.st = st; v.men = men; v.trp = trp; v.cnt = cnt; v.tspd = tspd;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic men, input logic trp,
                             input logic [7:0] cnt, input logic [15:0] tspd);
        check_output({tag, " state_o"},    16'(bus.state_o),    16'(st));
        check_output({tag, " motor_en"},   16'(bus.motor_en),   16'(men));
        check_output({tag, " trip"},       16'(bus.trip),       16'(trp));
        check_output({tag, " trip_count"}, 16'(bus.trip_count), 16'(cnt));
        check_output({tag, " trip_speed"}, bus.trip_speed,      tspd);
    endtask

    // Inputs change 1ns after a rising edge, held for the requested cycles, then outputs are checked.
    task automatic apply_stimulus(input vec_t v);
        bus.enable    = v.en;
        bus.fault_in  = v.flt;
        bus.clear_req = v.clr;
        bus.speed_in  = v.spd;
        repeat (v.cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.fault_in  = 1'b0;
        bus.clear_req = 1'b0;
        bus.speed_in  = 16'd0;

        //      en  flt clr spd     n     st  men trp cnt tspd
        add_vec(1, 0, 0, 16'd0,    1,    1, 1, 0, 0, 0);      // IDLE -> RUN
        add_vec(1, 1, 0, 16'd0,    1,    2, 1, 0, 0, 0);      // first fault -> PEND
        add_vec(1, 1, 0, 16'd0,    6,    2, 1, 0, 0, 0);      // 7 highs total
        add_vec(1, 0, 0, 16'd0,    1,    1, 1, 0, 0, 0);      // glitch rejected
        add_vec(1, 1, 0, 16'd1200, 7,    2, 1, 0, 0, 0);
        add_vec(1, 1, 0, 16'd1200, 1,    3, 0, 1, 1, SPD_A);  // 8th high trips
        add_vec(0, 1, 1, 16'd500,  3,    3, 0, 1, 1, SPD_A);  // enable/clear ignored in TRIP
        add_vec(0, 0, 1, 16'd500,  1,    4, 0, 1, 1, SPD_A);  // -> COOL, cool=0
        add_vec(1, 0, 0, 16'd500, 10,    4, 0, 1, 1, SPD_A);  // cool=10
        add_vec(1, 0, 1, 16'd500,  1,    4, 0, 1, 1, SPD_A);  // early clear ignored
        add_vec(1, 0, 0, 16'd500,  1,    4, 0, 1, 1, SPD_A);  // cool=12
        add_vec(1, 1, 0, 16'd900,  1,    3, 0, 1, 1, SPD_A);  // re-fault, count unchanged
        add_vec(1, 0, 0, 16'd0,    1,    4, 0, 1, 1, SPD_A);
        add_vec(1, 0, 0, 16'd0,   15,    4, 0, 1, 1, SPD_A);  // cool=15
        add_vec(1, 0, 1, 16'd0,    1,    4, 0, 1, 1, SPD_A);  // one cycle short
        add_vec(1, 1, 1, 16'd0,    1,    3, 0, 1, 1, SPD_A);  // fault beats clear at cool=16
        add_vec(1, 0, 0, 16'd0,    1,    4, 0, 1, 1, SPD_A);
        add_vec(1, 0, 0, 16'd0,   16,    4, 0, 1, 1, SPD_A);  // cool=16
        add_vec(0, 0, 0, 16'd0,    3,    4, 0, 1, 1, SPD_A);  // saturated, waits for clear
        add_vec(1, 0, 1, 16'd0,    1,    1, 1, 0, 1, SPD_A);  // clear with enable -> RUN
        add_vec(0, 1, 0, 16'd0,    1,    0, 0, 0, 1, SPD_A);  // enable=0 beats fault
        add_vec(1, 0, 0, 16'd0,    1,    1, 1, 0, 1, SPD_A);
        add_vec(1, 1, 0, 16'd777,  8,    3, 0, 1, 2, SPD_B);  // second trip
        add_vec(0, 0, 0, 16'd0,    1,    4, 0, 1, 2, SPD_B);
        add_vec(0, 0, 0, 16'd0,   16,    4, 0, 1, 2, SPD_B);
        add_vec(0, 0, 1, 16'd0,    1,    0, 0, 0, 2, SPD_B);  // clear without enable -> IDLE
        add_vec(1, 0, 0, 16'd0,    1,    1, 1, 0, 2, SPD_B);
        add_vec(1, 1, 0, 16'd0,    1,    2, 1, 0, 2, SPD_B);
        add_vec(0, 1, 0, 16'd0,    1,    0, 0, 0, 2, SPD_B);  // enable=0 exits PEND
        add_vec(1, 0, 0, 16'd0,    1,    1, 1, 0, 2, SPD_B);
        add_vec(1, 1, 0, 16'd0,    7,    2, 1, 0, 2, SPD_B);  // debounce restarted from 1
        add_vec(1, 1, 0, 16'd4321, 1,    3, 0, 1, 3, SPD_C);  // third trip

        #12;
        check_all("reset", 3'd0, 1'b0, 1'b0, 8'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post-reset idle", 3'd0, 1'b0, 1'b0, 8'd0, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].men, vecs[i].trp,
                      vecs[i].cnt, vecs[i].tspd);
        end

        // Asynchronous reset between edges while tripped clears everything without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 3'd0, 1'b0, 1'b0, 8'd0, 16'd0);
        bus.enable   = 1'b1;
        bus.fault_in = 1'b0;
        @(posedge clk);
        #1;
        check_all("held in reset", 3'd0, 1'b0, 1'b0, 8'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("restart run", 3'd1, 1'b1, 1'b0, 8'd0, 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
